riscv_core_muldiv_issue: RTL and testbench
==========================================

# riscv_core_muldiv_issue

Requester-side companion to the pipelined mul/div unit. Accepts mul/div ops from the core X stage and drives the unit's `muldivreq` port. Tracks in-flight destination registers in an in-order tag FIFO and a 32-bit pending scoreboard. Consumes `muldivresp`, selects the 32-bit architectural result, and presents it on a buffered writeback port.

## Interface
- `DEPTH`, 4: tag FIFO entries, i.e. max ops accepted but not yet responded; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `issue_val` in 1: X stage has a mul/div op.
- `issue_rdy` out 1: op accepted this cycle if `issue_val`.
- `issue_fn` in 3: `IMULDIV_MULDIVREQ_MSG_FUNC_*` encoding.
- `issue_a`, `issue_b` in 32: operands.
- `issue_rd` in 5: destination register.
- `muldivreq_msg_fn` out 3; `muldivreq_msg_a`, `muldivreq_msg_b` out 32: request message.
- `muldivreq_val` out 1; `muldivreq_rdy` in 1: request handshake.
- `muldivresp_msg_result` in 64; `muldivresp_val` in 1; `muldivresp_rdy` out 1: response handshake.
- `wb_val` out 1; `wb_rdy` in 1; `wb_rd` out 5; `wb_data` out 32: writeback port.
- `sb_raddr0`, `sb_raddr1` in 5; `sb_busy0`, `sb_busy1` out 1: scoreboard lookup for hazard detection.
- `busy` out 1: any op in flight (FIFO non-empty or `wb_val`).
- `err` out 1: sticky protocol-error flag.

## Operation
- **Issue hazard**: `hz = (issue_rd != 0) && pending[issue_rd]`, using the registered `pending` value, so a same-cycle clear does not lift the block.
- **Issue path**: combinational pass-through.
  - `muldivreq_msg_*` = `issue_*`.
  - `muldivreq_val = issue_val && !fifo_full && !hz`.
  - `issue_rdy = muldivreq_rdy && !fifo_full && !hz`.
  - `go = issue_val && issue_rdy`.
- **On `go`**:
  - Push {fn, rd} into the tag FIFO.
  - Set `pending[rd]` if rd≠0.
  - rd=0 ops are still pushed, to preserve ordering.
- **Full FIFO**: blocks issue even if a pop happens the same cycle. No bypass.
- **Response acceptance**: `muldivresp_rdy = !wb_val || wb_rdy`. A response fires when `muldivresp_val && muldivresp_rdy`.
- **On response fire**, pop the FIFO head {fn, rd}:
  - If rd≠0: load `wb_rd` = rd and `wb_data` = sel(fn, result), and set `wb_val`.
  - If rd=0: drop the result, and clear `wb_val` if it is being drained.
- **Result select**:
  - MUL, DIV, DIVU → `result[31:0]`.
  - REM, REMU → `result[63:32]`.
  - Any other fn → 0.
- **Writeback fire** (`wb_val && wb_rdy`): clear `pending[wb_rd]`. `wb_val` drops unless a new response loads the register in the same cycle.
- **Scoreboard lookup**: `sb_busyN = pending[sb_raddrN]` (combinational from the register). Index 0 always reads 0.
- **Protocol error**: a response fire with the FIFO empty sets `err`. Nothing is popped and nothing is written back. `err` clears only on reset.
- **Pointers**: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is determined by an occupancy counter of width log2(DEPTH)+1.

## Timing
- **Reset** (asynchronous assert, outputs valid immediately):
  - FIFO empty; `pending` = 0.
  - `wb_val`, `wb_rd`, `wb_data`, `err`, `busy` = 0.
  - Hence `issue_rdy` = `muldivreq_rdy`, `muldivresp_rdy` = 1, `sb_busy*` = 0.
- **Reset deassertion**: takes effect at the next `clk` edge.
- **Issue**: zero latency. `pending[rd]` is visible on `sb_busy*` the cycle after the `go` edge.
- **Response to writeback**: `wb_val` asserts the cycle after the response fire. `wb_val`, `wb_rd` and `wb_data` are stable until `wb_rdy`.
- **Back-to-back**: with `wb_rdy` held high, one writeback per cycle is sustained.
- **Same-cycle push and pop**: occupancy is unchanged and both pointers advance.
- **Same-cycle writeback fire and new response**: `wb_*` reloads with no bubble.
- **Hazard release**: `pending[rd]` clears at the edge of the writeback fire. An issue to the same rd is accepted in the following cycle at the earliest.

## Test plan
- **Single MUL**: after reset, MUL a=3, b=0xFFFFFFFB, rd=7 → `wb_rd`=7, `wb_data`=0xFFFFFFF1 one cycle after the response. `sb_busy0` (raddr0=7) is high from the cycle after issue until the cycle after the wb fire.
- **Select**: REM a=0xFFFFFFF9, b=2, rd=5 → `wb_data`=0xFFFFFFFF. DIVU a=7, b=2, rd=6 → 3. DIV a=0xFFFFFFF9, b=2 → 0xFFFFFFFD. Results retire in issue order.
- **Full / backpressure**: DEPTH=4, `wb_rdy`=0, six issues to rd=1..6 → exactly 4 accepted, then `issue_rdy`=0. After `wb_rdy`=1, the remaining ops drain in order 1,2,3,4 and issue reopens.
- **WAW hazard**: issue rd=9 while rd=9 is pending → `issue_rdy`=0 and `muldivreq_val`=0 through the wb fire cycle. Accepted in the cycle after.
- **rd=0**: MUL rd=0 → FIFO pops, no `wb_val`, `busy` returns to 0. A response with the FIFO empty → `err`=1, no `wb_val`.
- **Async reset mid-flight**: assert `reset` low with 3 ops in flight and `wb_val`=1 → `wb_val`, `busy`, `sb_busy*` drop without a clock edge. After release, a new MUL completes correctly.

Source files
------------

// File: rtl/riscv_core_muldiv_issue.sv
// Requester-side front end for the pipelined mul/div unit: issues ops, tracks
// in-flight destinations (tag FIFO + pending scoreboard) and buffers writeback.
module riscv_core_muldiv_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_val,
  output logic        issue_rdy,
  input  logic [2:0]  issue_fn,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic [2:0]  muldivreq_msg_fn,
  output logic [31:0] muldivreq_msg_a,
  output logic [31:0] muldivreq_msg_b,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  input  logic [63:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [4:0]  sb_raddr0,
  input  logic [4:0]  sb_raddr1,
  output logic        sb_busy0,
  output logic        sb_busy1,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  logic [2:0]    tag_fn [DEPTH];
  logic [4:0]    tag_rd [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   pending, pending_nxt;

  logic fifo_full, fifo_empty, hz, go, resp_fire, pop, wb_fire;
  logic [2:0] head_fn;
  logic [4:0] head_rd;

  function automatic logic [31:0] sel_result(input logic [2:0] fn, input logic [63:0] r);
    case (fn)
      FN_MUL, FN_DIV, FN_DIVU: sel_result = r[31:0];
      FN_REM, FN_REMU:         sel_result = r[63:32];
      default:                 sel_result = 32'd0;
    endcase
  endfunction

  // Every channel uses valid/ready: a transfer happens on a clock edge where
  // both are high; the hazard uses registered pending, so a same-cycle
  // writeback never unblocks an issue to the same rd.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign hz         = (issue_rd != 5'd0) && pending[issue_rd];

  assign muldivreq_msg_fn = issue_fn;
  assign muldivreq_msg_a  = issue_a;
  assign muldivreq_msg_b  = issue_b;
  assign muldivreq_val    = issue_val && !fifo_full && !hz;
  assign issue_rdy        = muldivreq_rdy && !fifo_full && !hz;
  assign go               = issue_val && issue_rdy;

  assign muldivresp_rdy = !wb_val || wb_rdy;
  assign resp_fire      = muldivresp_val && muldivresp_rdy;
  assign pop            = resp_fire && !fifo_empty;
  assign wb_fire        = wb_val && wb_rdy;

  assign head_fn = tag_fn[rptr];
  assign head_rd = tag_rd[rptr];

  assign sb_busy0 = (sb_raddr0 != 5'd0) && pending[sb_raddr0];
  assign sb_busy1 = (sb_raddr1 != 5'd0) && pending[sb_raddr1];
  assign busy     = !fifo_empty || wb_val;

  always_comb begin
    pending_nxt = pending;
    if (wb_fire) pending_nxt[wb_rd] = 1'b0;
    if (go && issue_rd != 5'd0) pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (go) begin
      tag_fn[wptr] <= issue_fn;
      tag_rd[wptr] <= issue_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pending <= '0;
      wb_val  <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
      err     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (go)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({go, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // rd=0 results are discarded but still retire their FIFO slot in order.
      if (pop && head_rd != 5'd0) begin
        wb_val  <= 1'b1;
        wb_rd   <= head_rd;
        wb_data <= sel_result(head_fn, muldivresp_msg_result);
      end else if (wb_fire) begin
        wb_val <= 1'b0;
      end
      if (resp_fire && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core_muldiv_issue.sv
// Randomized bench for riscv_core_muldiv_issue: a stand-in mul/div unit plus a
// queue-based reference model of issue, retirement and the pending scoreboard.
module tb_riscv_core_muldiv_issue;

  localparam int DEPTH = 4;

  logic        clk, reset;
  logic        issue_val, issue_rdy;
  logic [2:0]  issue_fn;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic        wb_val, wb_rdy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  sb_raddr0, sb_raddr1;
  logic        sb_busy0, sb_busy1, busy, err;

  riscv_core_muldiv_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_val(issue_val), .issue_rdy(issue_rdy), .issue_fn(issue_fn),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy), .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_raddr0(sb_raddr0), .sb_raddr1(sb_raddr1),
    .sb_busy0(sb_busy0), .sb_busy1(sb_busy1), .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // scoreboard state
  typedef struct { logic [4:0] rd; logic [31:0] data; } tag_t;
  typedef struct { logic [2:0] fn; logic [31:0] a; logic [31:0] b; } req_t;

  tag_t        exp_q[$];
  req_t        unit_q[$];
  logic [4:0]  ret_rd[$];
  logic [31:0] ret_data[$];
  bit [31:0]   m_pend;
  bit          m_wbval, m_err, force_err;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbdata;
  logic        obs_irdy, obs_mval, obs_wbval, obs_busy, obs_err, obs_sb0;
  logic [4:0]  obs_wbrd;
  logic [31:0] obs_wbdata;
  int          n_checks, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // architectural result of an op, straight from the ISA definition
  function automatic logic [31:0] exp_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      3'd0:    r = a * b;
      3'd1:    r = $signed(a) / $signed(b);
      3'd2:    r = a / b;
      3'd3:    r = $signed(a) % $signed(b);
      3'd4:    r = a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // raw 64-bit response of the unit: full product, or {remainder, quotient}
  function automatic logic [63:0] unit_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] q, m;
    case (fn)
      3'd0: r = {32'd0, a} * {32'd0, b};
      3'd1, 3'd3: begin
        q = $signed(a) / $signed(b);
        m = $signed(a) % $signed(b);
        r = {m, q};
      end
      3'd2, 3'd4: r = {a % b, a / b};
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // driver: one clock cycle of stimulus, output checks, then model update
  task automatic step(input bit iv, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit mrdy, input bit rv_req, input bit wrdy,
                      input logic [4:0] r0, input logic [4:0] r1);
    bit full, hz, e_irdy, e_mval, e_rrdy, go, rfire, wfire, mfire, rfire_obs, rv;
    tag_t t;
    @(negedge clk);
    rv = rv_req && (unit_q.size() > 0 || force_err);
    issue_val = iv; issue_fn = fn; issue_a = a; issue_b = b; issue_rd = rd;
    muldivreq_rdy = mrdy;
    muldivresp_val = rv;
    muldivresp_msg_result = (unit_q.size() > 0) ?
      unit_result(unit_q[0].fn, unit_q[0].a, unit_q[0].b) : {$urandom, $urandom};
    wb_rdy = wrdy; sb_raddr0 = r0; sb_raddr1 = r1;
    #1;
    full   = exp_q.size() >= DEPTH;
    hz     = (rd != 5'd0) && m_pend[rd];
    e_irdy = mrdy && !full && !hz;
    e_mval = iv && !full && !hz;
    e_rrdy = !m_wbval || wrdy;
    check("issue_rdy", issue_rdy, e_irdy);
    check("req_val", muldivreq_val, e_mval);
    check("req_fn", muldivreq_msg_fn, fn);
    check("req_a", muldivreq_msg_a, a);
    check("req_b", muldivreq_msg_b, b);
    check("resp_rdy", muldivresp_rdy, e_rrdy);
    check("sb_busy0", sb_busy0, (r0 != 5'd0) && m_pend[r0]);
    check("sb_busy1", sb_busy1, (r1 != 5'd0) && m_pend[r1]);
    check("busy", busy, (exp_q.size() != 0) || m_wbval);
    check("err", err, m_err);
    check("wb_val", wb_val, m_wbval);
    if (m_wbval) begin
      check("wb_rd", wb_rd, m_wbrd);
      check("wb_data", wb_data, m_wbdata);
    end
    obs_irdy = issue_rdy; obs_mval = muldivreq_val; obs_wbval = wb_val; obs_busy = busy;
    obs_err = err; obs_sb0 = sb_busy0; obs_wbrd = wb_rd; obs_wbdata = wb_data;
    if (wb_val && wrdy) begin
      ret_rd.push_back(wb_rd);
      ret_data.push_back(wb_data);
    end
    mfire     = muldivreq_val && muldivreq_rdy;
    rfire_obs = rv && muldivresp_rdy;
    @(posedge clk);
    go = iv && e_irdy; rfire = rv && e_rrdy; wfire = m_wbval && wrdy;
    if (wfire) begin
      m_pend[m_wbrd] = 1'b0;
      m_wbval = 1'b0;
    end
    if (rfire) begin
      if (exp_q.size() == 0) m_err = 1'b1;
      else begin
        t = exp_q.pop_front();
        if (t.rd != 5'd0) begin
          m_wbval = 1'b1; m_wbrd = t.rd; m_wbdata = t.data;
        end
      end
    end
    if (go) begin
      exp_q.push_back(tag_t'{rd, exp_result(fn, a, b)});
      if (rd != 5'd0) m_pend[rd] = 1'b1;
    end
    if (mfire) unit_q.push_back(req_t'{fn, a, b});
    if (rfire_obs && unit_q.size() > 0) void'(unit_q.pop_front());
  endtask

  task automatic idle(input bit rv, input bit wrdy, input logic [4:0] r0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, rv, wrdy, r0, 5'd0);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || m_wbval) && k < 300) begin
      idle(1'b1, 1'b1, 5'd0);
      k++;
    end
    check("drain_done", (exp_q.size() == 0) && !m_wbval, 1);
  endtask

  // asynchronous reset: outputs are checked before any clock edge
  task automatic do_reset(input logic [4:0] probe);
    @(negedge clk);
    #2;
    issue_val = 1'b1; issue_rd = probe; muldivreq_rdy = 1'b1; muldivresp_val = 1'b0;
    wb_rdy = 1'b0; sb_raddr0 = probe; sb_raddr1 = probe;
    reset = 1'b0;
    #1;
    check("rst_wb_val", wb_val, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sb_busy0", sb_busy0, 0);
    check("rst_sb_busy1", sb_busy1, 0);
    check("rst_resp_rdy", muldivresp_rdy, 1);
    check("rst_issue_rdy_hi", issue_rdy, 1);
    muldivreq_rdy = 1'b0;
    #1;
    check("rst_issue_rdy_lo", issue_rdy, 0);
    issue_val = 1'b0;
    exp_q.delete(); unit_q.delete();
    m_pend = '0; m_wbval = 1'b0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rand_op(output logic [2:0] fn, output logic [31:0] a, output logic [31:0] b,
                         output logic [4:0] rd);
    fn = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
    if (fn >= 3'd1 && fn <= 3'd4 && b == 32'd0) b = 32'd1;
    if ((fn == 3'd1 || fn == 3'd3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
    rd = 5'($urandom_range(0, 7));
  endtask

  initial begin
    int acc;
    int wprob[5] = '{90, 50, 10, 100, 30};
    logic [2:0] fn;
    logic [31:0] a, b;
    logic [4:0] rd;
    n_checks = 0; n_err = 0; force_err = 1'b0;
    reset = 1'b0; issue_val = 1'b0; issue_fn = 3'd0; issue_a = 32'd0; issue_b = 32'd0;
    issue_rd = 5'd0; muldivreq_rdy = 1'b0; muldivresp_val = 1'b0; muldivresp_msg_result = 64'd0;
    wb_rdy = 1'b0; sb_raddr0 = 5'd0; sb_raddr1 = 5'd0;
    do_reset(5'd7);

    // single MUL with scoreboard visibility window
    step(1'b1, 3'd0, 32'd3, 32'hFFFF_FFFB, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
    check("mul_accept", obs_irdy, 1);
    idle(1'b0, 1'b0, 5'd7);
    check("mul_sb_set", obs_sb0, 1);
    idle(1'b1, 1'b0, 5'd7);
    idle(1'b0, 1'b1, 5'd7);
    check("mul_wb_val", obs_wbval, 1);
    check("mul_wb_rd", obs_wbrd, 7);
    check("mul_wb_data", obs_wbdata, 32'hFFFF_FFF1);
    check("mul_sb_held", obs_sb0, 1);
    idle(1'b0, 1'b0, 5'd7);
    check("mul_sb_clear", obs_sb0, 0);

    // result select and in-order retirement
    ret_rd.delete(); ret_data.delete();
    step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 3'd2, 32'd7, 32'd2, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 3'd1, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    drain();
    check("sel_count", ret_rd.size(), 3);
    if (ret_rd.size() == 3) begin
      check("sel_rem_rd", ret_rd[0], 5);  check("sel_rem", ret_data[0], 32'hFFFF_FFFF);
      check("sel_divu_rd", ret_rd[1], 6); check("sel_divu", ret_data[1], 32'd3);
      check("sel_div_rd", ret_rd[2], 8);  check("sel_div", ret_data[2], 32'hFFFF_FFFD);
    end

    // full FIFO under writeback backpressure
    ret_rd.delete(); ret_data.delete();
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 3'd0, 32'(i), 32'd3, 5'(i), 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      if (obs_irdy) acc++;
    end
    check("full_accepts", acc, DEPTH);
    check("full_blocked", obs_irdy, 0);
    drain();
    check("full_count", ret_rd.size(), 4);
    for (int i = 0; i < 4 && i < ret_rd.size(); i++) check("full_order", ret_rd[i], i + 1);
    step(1'b1, 3'd0, 32'd2, 32'd2, 5'd10, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    check("full_reopen", obs_irdy, 1);
    drain();

    // WAW hazard held through the writeback fire cycle
    step(1'b1, 3'd0, 32'd5, 32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 3'd0, 32'd1, 32'd1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    check("waw_blk_resp", obs_irdy, 0);
    step(1'b1, 3'd0, 32'd1, 32'd1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    check("waw_blk_wb", obs_irdy, 0);
    check("waw_blk_val", obs_mval, 0);
    step(1'b1, 3'd0, 32'd1, 32'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    check("waw_blk_fire", obs_irdy, 0);
    check("waw_blk_fire_val", obs_mval, 0);
    step(1'b1, 3'd0, 32'd1, 32'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    check("waw_release", obs_irdy, 1);
    drain();

    // rd=0 retires silently; a stray response sets err
    step(1'b1, 3'd0, 32'd4, 32'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    idle(1'b1, 1'b1, 5'd0);
    idle(1'b0, 1'b1, 5'd0);
    check("rd0_no_wb", obs_wbval, 0);
    check("rd0_idle", obs_busy, 0);
    force_err = 1'b1;
    idle(1'b1, 1'b1, 5'd0);
    force_err = 1'b0;
    idle(1'b0, 1'b1, 5'd0);
    check("err_set", obs_err, 1);
    check("err_no_wb", obs_wbval, 0);

    // randomized traffic with varying writeback backpressure
    do_reset(5'd0);
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 300; c++) begin
        rand_op(fn, a, b, rd);
        step($urandom_range(0, 99) < 60, fn, a, b, rd, $urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < wprob[s],
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    drain();

    // async reset with ops in flight
    step(1'b1, 3'd0, 32'd2, 32'd3, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 3'd0, 32'd4, 32'd5, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 3'd0, 32'd6, 32'd7, 5'd13, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(1'b1, 1'b0, 5'd0);
    idle(1'b0, 1'b0, 5'd11);
    check("mid_wb_val", obs_wbval, 1);
    check("mid_sb", obs_sb0, 1);
    do_reset(5'd12);
    ret_rd.delete(); ret_data.delete();
    step(1'b1, 3'd0, 32'd6, 32'd7, 5'd11, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
    check("post_rst_accept", obs_irdy, 1);
    drain();
    check("post_rst_count", ret_rd.size(), 1);
    if (ret_rd.size() == 1) begin
      check("post_rst_rd", ret_rd[0], 11);
      check("post_rst_data", ret_data[0], 42);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
